// File: rtl/ahb2_dma_copy.sv
// ahb2_dma_copy: single-channel AHB2 master that copies len words src -> dst.
// Ports: start/src_addr/dst_addr/len in; busy/done/err status; AHB2 master bus.
// Build option: define AHB2_DMA_OVERLAP_EN to overlap next read addr with write data.
module ahb2_dma_copy #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          haddr,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [2:0]           hburst,
  output logic [31:0]          hwdata,
  input  logic [31:0]          hrdata,
  input  logic                 hready,
  input  logic                 hresp
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_A,
    S_WR_D,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // err_q doubles as the abort flag: it is cleared at every accepted
  // start, so within a copy it is set only by this copy's error.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    htrans  = TR_IDLE;
    hwrite  = 1'b0;
    haddr   = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = {src_addr[31:2], 2'b00};
          dst_d = {dst_addr[31:2], 2'b00};
          cnt_d = len;
          err_d = 1'b0;
          state_d = (len == '0) ? S_FIN : S_RD_A;
        end
      end
      S_RD_A: begin
        busy   = 1'b1;
        htrans = TR_NONSEQ;
        haddr  = src_q;
        if (hready) begin
          src_d   = src_q + 32'd4;
          state_d = S_RD_D;
        end
      end
      S_RD_D: begin
        busy = 1'b1;
        if (hresp) err_d = 1'b1;
        if (hready) begin
          if (hresp || err_q) begin
            state_d = S_FIN;
          end else begin
            buf_d   = hrdata;
            state_d = S_WR_A;
          end
        end
      end
      S_WR_A: begin
        busy   = 1'b1;
        htrans = TR_NONSEQ;
        hwrite = 1'b1;
        haddr  = dst_q;
        if (hready) begin
          dst_d   = dst_q + 32'd4;
          wdata_d = buf_q;
          state_d = S_WR_D;
        end
      end
      S_WR_D: begin
        busy = 1'b1;
`ifdef AHB2_DMA_OVERLAP_EN
        if (cnt_q > LEN_WIDTH'(1) && !err_q) begin
          htrans = TR_NONSEQ;
          haddr  = src_q;
        end
`endif
        if (hresp) err_d = 1'b1;
        if (hready) begin
          if (hresp || err_q) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_d = S_FIN;
            end else begin
`ifdef AHB2_DMA_OVERLAP_EN
              src_d   = src_q + 32'd4;
              state_d = S_RD_D;
`else
              state_d = S_RD_A;
`endif
            end
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err    = err_q;
  assign hwdata = wdata_q;
  assign hsize  = 3'b010;
  assign hburst = 3'b000;

endmodule

// File: tb/tb_ahb2_dma_copy.sv
// tb_ahb2_dma_copy: AHB2 slave memory model plus scoreboard bench.
// Expected reads/writes queued at stimulus; negedge monitor pops and checks.
module tb_ahb2_dma_copy;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_addr = '0;
  logic [31:0]   dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;
  logic [31:0]   haddr, hwdata, hrdata;
  logic [1:0]    htrans;
  logic          hwrite, hready, hresp;
  logic [2:0]    hsize, hburst;

  ahb2_dma_copy #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory: word-indexed; unwritten words have a fixed pattern
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] rd_word(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    if (w < 30'd64) return {2'b00, w};
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  int cfg_wrd = 0;
  int cfg_wwr = 0;
  int cfg_err = -1;

  logic        dp_v, dp_w, dp_e, dp_ep;
  logic [29:0] dp_a;
  logic [31:0] dp_rd;
  int          dp_wait, rd_cnt;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'hDEAD_BEEF;
    if (dp_v) begin
      if (dp_e) begin
        hresp  = 1'b1;
        hready = dp_ep;
      end else if (dp_wait > 0) begin
        hready = 1'b0;
      end else if (!dp_w) begin
        hrdata = dp_rd;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v <= 1'b0; dp_w <= 1'b0; dp_e <= 1'b0; dp_ep <= 1'b0;
      dp_a <= '0; dp_rd <= '0; dp_wait <= 0; rd_cnt <= 0;
    end else begin
      if (start) rd_cnt <= 0;
      if (dp_v) begin
        if (hready) begin
          dp_v <= 1'b0;
          if (dp_w && !dp_e) mem[dp_a] = hwdata;
        end else if (dp_e) begin
          dp_ep <= 1'b1;
        end else begin
          dp_wait <= dp_wait - 1;
        end
      end
      if (htrans == 2'b10 && hready) begin
        dp_v    <= 1'b1;
        dp_w    <= hwrite;
        dp_a    <= haddr[31:2];
        dp_ep   <= 1'b0;
        dp_wait <= hwrite ? cfg_wwr : cfg_wrd;
        dp_e    <= !hwrite && (rd_cnt == cfg_err);
        dp_rd   <= rd_word(haddr[31:2]);
        if (!hwrite) rd_cnt <= rd_cnt + 1;
      end
    end
  end

  logic [31:0] exp_raddr[$];
  logic [31:0] exp_waddr[$];
  logic [31:0] exp_wdata[$];
  int          nonseq_after_err = 0;
  bit          err_obs = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        err_obs = 1'b0;
        nonseq_after_err = 0;
      end
      if (err_obs && htrans != 2'b00) nonseq_after_err++;
      if (hresp) err_obs = 1'b1;
      if (dp_v && dp_w && hready && !hresp) begin
        if (exp_waddr.size() == 0) begin
          chk("unexpected_write", {dp_a, 2'b00}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", {dp_a, 2'b00}, exp_waddr.pop_front());
          chk("wr_data", hwdata, exp_wdata.pop_front());
        end
      end
      if (htrans == 2'b10 && !hwrite && hready) begin
        if (exp_raddr.size() == 0) begin
          chk("unexpected_read", haddr, 32'hFFFF_FFFF);
        end else begin
          chk("rd_addr", haddr, exp_raddr.pop_front());
          chk("rd_ctl", {26'd0, hsize, hburst}, 32'h10);
        end
      end
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int n, input int wrd, input int wwr,
                          input int erri, input bit timed);
    logic [31:0] sp, dpt, a;
    int nr, nw, exp_done, cyc, busy_bad;
    bit has_err;
    cfg_wrd = wrd;
    cfg_wwr = wwr;
    cfg_err = erri;
    sp  = {s[31:2], 2'b00};
    dpt = {d[31:2], 2'b00};
    has_err = (erri >= 0) && (erri < n);
    nr = has_err ? erri + 1 : n;
    nw = has_err ? erri : n;
    for (int i = 0; i < nr; i++) exp_raddr.push_back(sp + 32'(4 * i));
    for (int i = 0; i < nw; i++) begin
      a = sp + 32'(4 * i);
      exp_waddr.push_back(dpt + 32'(4 * i));
      exp_wdata.push_back(rd_word(a[31:2]));
    end
`ifdef AHB2_DMA_OVERLAP_EN
    exp_done = (n == 0) ? 1 : 3 * n + 2 + n * (wrd + wwr);
`else
    exp_done = (n == 0) ? 1 : 4 * n + 1 + n * (wrd + wwr);
`endif
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = LW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_bad = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy !== !done) busy_bad++;
      if (done === 1'b1) break;
      if (cyc >= 3000) begin
        chk("done_timeout", 32'(cyc), 32'(exp_done));
        break;
      end
    end
    if (timed) chk("done_cycle", 32'(cyc), 32'(exp_done));
    chk("err_flag", {31'd0, err}, {31'd0, has_err});
    chk("busy_shape", 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk("done_pulse", {30'd0, done, busy}, 32'd0);
    chk("nonseq_after_err", 32'(nonseq_after_err), 32'd0);
    chk("rd_left", 32'(exp_raddr.size()), 32'd0);
    chk("wr_left", 32'(exp_waddr.size()), 32'd0);
  endtask

  initial begin
    int wd, n;
    bit seen;
    logic [31:0] s, d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", {29'd0, busy, done, err}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_hsize", {29'd0, hsize}, 32'd2);
    chk("rst_hburst", {29'd0, hburst}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_copy(32'h0, 32'h100, 4, 0, 0, -1, 1'b1);
    for (int i = 0; i < 4; i++)
      chk("t1_mem", rd_word(30'h40 + 30'(i)), 32'(i));

    run_copy(32'h1000_0000, 32'h2000_0000, 3, 0, 0, 1, 1'b0);

    run_copy(32'h1000_0040, 32'h2000_0040, 0, 0, 0, -1, 1'b1);

    run_copy(32'h1000_0080, 32'h2000_0080, 2, 2, 0, -1, 1'b1);

    run_copy(32'hFFFF_FFFC, 32'h300, 2, 0, 0, -1, 1'b1);
    chk("wrap_mem1", rd_word(30'hC1), rd_word(30'h0));

    // reset in the first write address phase
    cfg_wrd = 0; cfg_wwr = 0; cfg_err = -1;
    exp_raddr.push_back(32'h1000_0100);
    @(posedge clk); #1;
    src_addr = 32'h1000_0100; dst_addr = 32'h2000_0100;
    len = LW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (htrans == 2'b10 && hwrite) seen = 1'b1;
    end
    chk("rst_reach_wra", {31'd0, seen}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_htrans", {30'd0, htrans}, 32'd0);
    chk("mid_rst_status", {29'd0, busy, done, hwrite}, 32'd0);
    chk("mid_rst_rd_left", 32'(exp_raddr.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_copy(32'h1000_0100, 32'h2000_0200, 4, 0, 0, -1, 1'b1);

    for (int t = 0; t < 24; t++) begin
      n  = $urandom_range(0, 8);
      s  = 32'h1000_0000 + 32'($urandom_range(0, 255) << 2)
           + 32'($urandom_range(0, 3));
      d  = 32'h2000_1000 + 32'($urandom_range(0, 255) << 2)
           + 32'($urandom_range(0, 3));
      wd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      run_copy(s, d, n, $urandom_range(0, 2), $urandom_range(0, 2),
               wd, (wd < 0) || (wd >= n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
